array_pingpong_bank: RTL

- Parametrised double-buffered register bank built from 2-D unpacked arrays, organised as LANES x DEPTH elements of WIDTH bits.
- The producer writes single elements into the back bank; a commit handshake swaps banks and publishes the back bank as a whole-array snapshot.
- The snapshot output is a whole-array ternary between the two banks; there is no per-element mux.
- Sits between configuration/coefficient producers and consumers needing an atomic, tear-free table view.

---
 rtl/array_pingpong_pkg.sv | 15 +
 rtl/array_pingpong_bank_if.sv | 34 +++
 rtl/array_pingpong_store.sv | 38 +++
 rtl/array_pingpong_bank.sv | 108 ++++++++++
 4 files changed

// File: rtl/array_pingpong_pkg.sv
// Shared types and helpers for the ping-pong register bank.
package array_pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        DIRTY = 2'd1,
        SWAP  = 2'd2
    } state_e;

    // Index width for an n-entry dimension, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_pingpong_bank_if.sv
// Producer/consumer bundle of the ping-pong bank: element writes, commit handshake, snapshot.
interface array_pingpong_bank_if
    import array_pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LW = idx_w(LANES);
    localparam int unsigned AW = idx_w(DEPTH);

    logic             wr_en;
    logic [LW-1:0]    wr_lane;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_drop;
    logic             commit_valid;
    logic             commit_ready;
    logic [WIDTH-1:0] out_arr [LANES][DEPTH];
    logic             out_valid;
    logic [CNT_W-1:0] commit_cnt;

    modport master (
        output wr_en, wr_lane, wr_addr, wr_data, commit_valid,
        input  wr_drop, commit_ready, out_arr, out_valid, commit_cnt
    );

    modport slave (
        input  wr_en, wr_lane, wr_addr, wr_data, commit_valid,
        output wr_drop, commit_ready, out_arr, out_valid, commit_cnt
    );

endinterface

// File: rtl/array_pingpong_store.sv
// One bank of the ping-pong pair: single-element write plus whole-array load.
module array_pingpong_store
    import array_pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LANES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic [idx_w(LANES)-1:0]      lane_i,
    input  logic [idx_w(DEPTH)-1:0]      addr_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         load_i,
    input  logic [WIDTH-1:0]             load_arr_i [LANES][DEPTH],
    output logic [WIDTH-1:0]             mem_o      [LANES][DEPTH]
);

    logic [WIDTH-1:0] mem_q [LANES][DEPTH];

    // A write in the same cycle as a load overrides that one element.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            if (load_i) begin
                mem_q <= load_arr_i;
            end
            if (we_i) begin
                mem_q[lane_i][addr_i] <= data_i;
            end
        end
    end

    assign mem_o = mem_q;

endmodule

// File: rtl/array_pingpong_bank.sv
// Double-buffered LANES x DEPTH register bank with atomic commit/swap.
// Define ARRAY_PINGPONG_COPY_EN to seed the new back bank with the published snapshot.
module array_pingpong_bank
    import array_pingpong_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LANES       = 2,
    parameter int unsigned CNT_W       = 8,
    parameter bit          ALLOW_EMPTY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    array_pingpong_bank_if.slave  bus
);

    state_e           state_q;
    logic             bank_sel_q;
    logic             out_valid_q;
    logic             wr_drop_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] bank0_q [LANES][DEPTH];
    logic [WIDTH-1:0] bank1_q [LANES][DEPTH];

    logic commit_ready_c;
    logic commit_fire;
    logic wr_in_range;
    logic wr_acc;
    logic copy_fire;

    assign commit_ready_c = (state_q == DIRTY) || ((state_q == EMPTY) && ALLOW_EMPTY);
    assign commit_fire    = bus.commit_valid && commit_ready_c;
    assign wr_in_range    = (32'(bus.wr_lane) < LANES) && (32'(bus.wr_addr) < DEPTH);
    assign wr_acc         = bus.wr_en && (state_q != SWAP) && wr_in_range;

`ifdef ARRAY_PINGPONG_COPY_EN
    assign copy_fire = commit_fire;
`else
    assign copy_fire = 1'b0;
`endif

    // The back bank takes writes; on a copying commit the front bank reloads
    // from the back bank and also takes the same write, so both end up equal.
    array_pingpong_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wr_acc && (bank_sel_q || copy_fire)),
        .lane_i     (bus.wr_lane),
        .addr_i     (bus.wr_addr),
        .data_i     (bus.wr_data),
        .load_i     (copy_fire && !bank_sel_q),
        .load_arr_i (bank1_q),
        .mem_o      (bank0_q)
    );

    array_pingpong_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wr_acc && (!bank_sel_q || copy_fire)),
        .lane_i     (bus.wr_lane),
        .addr_i     (bus.wr_addr),
        .data_i     (bus.wr_data),
        .load_i     (copy_fire && bank_sel_q),
        .load_arr_i (bank0_q),
        .mem_o      (bank1_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            bank_sel_q  <= 1'b0;
            out_valid_q <= 1'b0;
            wr_drop_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_drop_q <= bus.wr_en && !wr_acc;
            unique case (state_q)
                EMPTY: begin
                    if (commit_fire) begin
                        state_q <= SWAP;
                    end else if (wr_acc) begin
                        state_q <= DIRTY;
                    end
                end
                DIRTY: begin
                    if (commit_fire) begin
                        state_q <= SWAP;
                    end
                end
                SWAP:    state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (commit_fire) begin
                bank_sel_q  <= ~bank_sel_q;
                out_valid_q <= 1'b1;
                cnt_q       <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_arr      = bank_sel_q ? bank1_q : bank0_q;
    assign bus.commit_ready = commit_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.wr_drop      = wr_drop_q;
    assign bus.commit_cnt   = cnt_q;

endmodule
